// File: rtl/softsign_denom_array_if.sv
`default_nettype none
// ============================================================================
// Module   : softsign_denom_array_if
// Brief    : Start/done handshake and lane buses of the softsign denominator.
// Revision : 1.0  initial release
// ============================================================================
interface softsign_denom_array_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
);
   logic                         start;
   logic                         mode;
   logic [CHANNELS*WIDTH-1:0]    X;
   logic                         busy;
   logic                         startout;
   logic [CHANNELS*WIDTH-1:0]    denom;
   logic [CHANNELS-1:0]          ovf;

   modport master (
      output start, mode, X,
      input  busy, startout, denom, ovf
   );

   modport slave (
      input  start, mode, X,
      output busy, startout, denom, ovf
   );
endinterface
`default_nettype wire

// File: rtl/softsign_denom_array.sv
`default_nettype none
// ============================================================================
// Module   : softsign_denom_array
// Brief    : Multi-lane 1+|x| / |x| denominator, one shared lane datapath per cycle.
// Revision : 1.0  initial release
// ============================================================================
module softsign_denom_array #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int SATURATE = 1
) (
   input  wire logic                 CLOCK,
   input  wire logic                 reset,
   softsign_denom_array_if.slave     bus
);

   localparam int c_idx_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [c_idx_w-1:0] c_last = c_idx_w'(CHANNELS - 1);
   localparam logic [WIDTH:0]     c_max  = {2'b00, {(WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_idx_w-1:0]   r_idx;
   logic                 r_mode;
   logic [WIDTH-1:0]     r_xs  [CHANNELS];
   logic [WIDTH-1:0]     r_den [CHANNELS];
   logic [CHANNELS-1:0]  r_ovf;
   logic                 r_busy;
   logic                 r_startout;

   logic [WIDTH-1:0]     w_x_in [CHANNELS];
   logic [WIDTH-1:0]     w_x;
   logic [WIDTH:0]       w_mag;
   logic [WIDTH:0]       w_raw;
   logic                 w_over;
   logic [WIDTH-1:0]     w_res;

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_lanes
         assign w_x_in[i]                    = bus.X[i*WIDTH +: WIDTH];
         assign bus.denom[i*WIDTH +: WIDTH]  = r_den[i];
      end
   endgenerate

   // One extra bit so that |MIN| and MAX+1 are representable before the overflow test
   assign w_x    = r_xs[r_idx];
   assign w_mag  = w_x[WIDTH-1] ? ({1'b0, ~w_x} + (WIDTH+1)'(1)) : {1'b0, w_x};
   assign w_raw  = w_mag + {{WIDTH{1'b0}}, ~r_mode};
   assign w_over = (w_raw > c_max);

   generate
      if (SATURATE != 0) begin : g_sat
         assign w_res = w_over ? c_max[WIDTH-1:0] : w_raw[WIDTH-1:0];
      end else begin : g_wrap
         assign w_res = w_raw[WIDTH-1:0];
      end
   endgenerate

   always_ff @(posedge CLOCK) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_ovf      <= '0;
         r_busy     <= 1'b0;
         r_startout <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            r_den[i] <= '0;
         end
      end else begin
         r_startout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_busy <= 1'b0;
               if (bus.start) begin
                  r_xs    <= w_x_in;
                  r_mode  <= bus.mode;
                  r_ovf   <= '0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_den[r_idx] <= w_res;
               r_ovf[r_idx] <= w_over;
               if (r_idx == c_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DONE: begin
               // Done pulse lands together with busy falling, so the IDLE cycle can accept
               r_startout <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state    <= S_IDLE;
               r_busy     <= 1'b0;
               r_startout <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.startout = r_startout;
   assign bus.ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_softsign_denom_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_softsign_denom_array
// Brief    : Scoreboard bench, saturating and wrapping instances on shared stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_softsign_denom_array;

   localparam int W  = 8;
   localparam int CH = 4;

   typedef struct {
      logic [CH*W-1:0] d;
      logic [CH-1:0]   o;
      int              e;
   } exp_t;

   logic            CLOCK = 1'b0;
   logic            reset;
   logic            start;
   logic            mode;
   logic [CH*W-1:0] X;
   int              ecnt = 0;
   int              n_total = 0;
   int              n_fail  = 0;
   exp_t            q1[$];
   exp_t            q0[$];

   softsign_denom_array_if #(.WIDTH(W), .CHANNELS(CH)) bus1 ();
   softsign_denom_array_if #(.WIDTH(W), .CHANNELS(CH)) bus0 ();

   assign bus1.start = start;
   assign bus1.mode  = mode;
   assign bus1.X     = X;
   assign bus0.start = start;
   assign bus0.mode  = mode;
   assign bus0.X     = X;

   softsign_denom_array #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1)) dut_sat (
      .CLOCK (CLOCK),
      .reset (reset),
      .bus   (bus1.slave)
   );

   softsign_denom_array #(.WIDTH(W), .CHANNELS(CH), .SATURATE(0)) dut_wrap (
      .CLOCK (CLOCK),
      .reset (reset),
      .bus   (bus0.slave)
   );

   always #5 CLOCK = ~CLOCK;
   always @(posedge CLOCK) ecnt <= ecnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitors: pop one expectation per done pulse
   always @(negedge CLOCK) begin
      if (bus1.startout) begin
         if (q1.size() == 0) begin
            chk("sat unexpected startout", 64'd1, 64'd0);
         end else begin
            exp_t x;
            x = q1.pop_front();
            chk("sat denom", 64'(bus1.denom), 64'(x.d));
            chk("sat ovf",   64'(bus1.ovf),   64'(x.o));
            chk("sat startout cycle", 64'(ecnt), 64'(x.e));
         end
      end
   end

   always @(negedge CLOCK) begin
      if (bus0.startout) begin
         if (q0.size() == 0) begin
            chk("wrap unexpected startout", 64'd1, 64'd0);
         end else begin
            exp_t x;
            x = q0.pop_front();
            chk("wrap denom", 64'(bus0.denom), 64'(x.d));
            chk("wrap ovf",   64'(bus0.ovf),   64'(x.o));
            chk("wrap startout cycle", 64'(ecnt), 64'(x.e));
         end
      end
   end

   task automatic push(input logic [CH*W-1:0] d1, input logic [CH-1:0] o1,
                       input logic [CH*W-1:0] d0, input logic [CH-1:0] o0);
      exp_t a;
      exp_t b;
      a.d = d1; a.o = o1; a.e = ecnt + CH + 1;
      b.d = d0; b.o = o0; b.e = ecnt + CH + 1;
      q1.push_back(a);
      q0.push_back(b);
   endtask

   task automatic op(input logic m, input logic [CH*W-1:0] x,
                     input logic [CH*W-1:0] d1, input logic [CH-1:0] o1,
                     input logic [CH*W-1:0] d0, input logic [CH-1:0] o0);
      @(negedge CLOCK);
      start = 1'b1;
      mode  = m;
      X     = x;
      @(posedge CLOCK);
      #1;
      start = 1'b0;
      push(d1, o1, d0, o0);
      chk("busy after capture", 64'(bus1.busy), 64'd1);
      chk("ovf cleared on capture", 64'(bus1.ovf), 64'd0);
      repeat (CH + 4) @(posedge CLOCK);
      #1;
      chk("busy idle", 64'(bus1.busy), 64'd0);
      chk("denom hold", 64'(bus1.denom), 64'(d1));
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      X     = '0;
      repeat (3) @(posedge CLOCK);
      #1;
      chk("reset denom",    64'(bus1.denom),    64'd0);
      chk("reset ovf",      64'(bus1.ovf),      64'd0);
      chk("reset busy",     64'(bus1.busy),     64'd0);
      chk("reset startout", 64'(bus1.startout), 64'd0);
      chk("reset wrap denom", 64'(bus0.denom),  64'd0);
      @(negedge CLOCK);
      reset = 1'b0;

      // {5,-3,0,127} mode 0
      op(1'b0, 32'h7F00FD05, 32'h7F010406, 4'b1000, 32'h80010406, 4'b1000);
      // {-128,-1,100,-127} mode 1
      op(1'b1, 32'h8164FF80, 32'h7F64017F, 4'b0001, 32'h7F640180, 4'b0001);
      // {-128,127,-127,0} mode 0
      op(1'b0, 32'h00817F80, 32'h017F7F7F, 4'b0111, 32'h01808081, 4'b0111);

      // Extra start pulses at edges k+2 and k+5, X changed after k+1
      @(negedge CLOCK);
      start = 1'b1;
      mode  = 1'b0;
      X     = 32'h40FFEC0A;
      @(posedge CLOCK);
      #1;
      start = 1'b0;
      push(32'h4102150B, 4'b0000, 32'h4102150B, 4'b0000);
      @(posedge CLOCK);
      #1;
      X    = 32'h7F7F7F7F;
      mode = 1'b1;
      @(negedge CLOCK);
      start = 1'b1;
      @(posedge CLOCK);
      #1;
      start = 1'b0;
      repeat (2) @(posedge CLOCK);
      @(negedge CLOCK);
      start = 1'b1;
      @(posedge CLOCK);
      #1;
      start = 1'b0;
      repeat (CH + 4) @(posedge CLOCK);
      #1;
      chk("ignored starts busy", 64'(bus1.busy), 64'd0);

      // Reset asserted at edge k+3 aborts the operation
      @(negedge CLOCK);
      start = 1'b1;
      mode  = 1'b1;
      X     = 32'h8164FF80;
      @(posedge CLOCK);
      #1;
      start = 1'b0;
      repeat (2) @(posedge CLOCK);
      @(negedge CLOCK);
      reset = 1'b1;
      @(posedge CLOCK);
      #1;
      chk("abort denom",    64'(bus1.denom),    64'd0);
      chk("abort ovf",      64'(bus1.ovf),      64'd0);
      chk("abort busy",     64'(bus1.busy),     64'd0);
      chk("abort startout", 64'(bus1.startout), 64'd0);
      @(negedge CLOCK);
      reset = 1'b0;
      repeat (CH + 4) @(posedge CLOCK);
      // {0,-5,7,-128} mode 1
      op(1'b1, 32'h8007FB00, 32'h7F070500, 4'b1000, 32'h80070500, 4'b1000);

      // Back-to-back with start held high: captures every CH+2 edges
      @(negedge CLOCK);
      start = 1'b1;
      mode  = 1'b0;
      X     = 32'h00817F80;
      @(posedge CLOCK);
      #1;
      push(32'h017F7F7F, 4'b0111, 32'h01808081, 4'b0111);
      chk("b2b ovf clear A", 64'(bus1.ovf), 64'd0);
      mode = 1'b1;
      X    = 32'h04030201;
      repeat (CH + 2) @(posedge CLOCK);
      #1;
      push(32'h04030201, 4'b0000, 32'h04030201, 4'b0000);
      chk("b2b ovf clear B", 64'(bus1.ovf), 64'd0);
      chk("b2b busy B", 64'(bus1.busy), 64'd1);
      mode = 1'b0;
      X    = 32'h0100FFFE;
      repeat (CH + 2) @(posedge CLOCK);
      #1;
      start = 1'b0;
      push(32'h02010203, 4'b0000, 32'h02010203, 4'b0000);
      chk("b2b busy C", 64'(bus1.busy), 64'd1);

      for (int i = 0; i < 50; i++) begin
         if (q1.size() == 0 && q0.size() == 0) break;
         @(posedge CLOCK);
      end
      repeat (CH + 4) @(posedge CLOCK);
      #1;
      chk("sat queue drained",  64'(q1.size()), 64'd0);
      chk("wrap queue drained", 64'(q0.size()), 64'd0);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/softsign_denom_array.md
Name: softsign_denom_array

Overview:
- Multi-channel, parametrised successor to the single-lane softsign denominator; computes 1+|x| (or |x|) for CHANNELS signed lanes.
- Feeds the divider stage of the neuron activation path: result = x / (1+|x|).
- Uses one shared abs/increment datapath, time-multiplexed one lane per cycle.
- Adds overflow detection and optional saturation; start/done pulse handshake.

Parameters:
WIDTH  32  bit width of each signed input lane and each output lane
CHANNELS  4  number of lanes processed per operation (>=1)
SATURATE  1  1: overflowed lanes clamp to +max; 0: lanes wrap modulo 2^WIDTH

Ports:
CLOCK  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only while busy=0
mode  input  1  0: denom = 1+|x|; 1: denom = |x|; captured with start
X  input  CHANNELS*WIDTH  packed signed lanes, lane i at [i*WIDTH +: WIDTH]; captured with start
busy  output  1  high from the cycle after start is accepted until startout has been issued
startout  output  1  one-cycle done pulse; denom and ovf are valid while it is high
denom  output  CHANNELS*WIDTH  packed two's-complement results, same lane packing as X
ovf  output  CHANNELS  per-lane overflow flag for the last operation

Behaviour:
- Clock and reset: clock CLOCK; reset is synchronous and active-high. While reset=1 at a rising edge:
  - state <= IDLE, lane index <= 0
  - denom <= 0, ovf <= 0, startout <= 0, busy <= 0
- Reset takes priority over every other action. Reset during CALC or DONE aborts the operation and no startout is issued.
- State machine:
  - IDLE: busy=0. On start=1, capture X into shadow register Xs, capture mode, clear ovf, set index=0, go to CALC.
  - CALC: busy=1. Each cycle process lane Xs[index] and write denom lane[index] and ovf[index]. If index==CHANNELS-1, go to DONE; otherwise index+1.
  - DONE: busy=1, startout=1 for exactly this cycle, then go to IDLE.
  - Illegal or unused state encodings recover to IDLE with startout=0.
- Latency: start sampled at edge k. Lanes 0..CHANNELS-1 are written at edges k+1..k+CHANNELS. startout is high during the cycle after edge k+CHANNELS+1. Total throughput is one operation per CHANNELS+2 cycles.
- start while busy=1 (in CALC or DONE) is ignored, not queued. The earliest new start is accepted in the IDLE cycle following DONE.
- X and mode may change freely after capture; only the shadow copies are used.
- Lane arithmetic, with MAX = 2^(WIDTH-1)-1 and MIN = -2^(WIDTH-1):
  - mag = Xs[WIDTH-1] ? (~Xs + 1) : Xs, using WIDTH+1-bit internal width
  - raw = mag + (mode ? 0 : 1)
  - Overflow when raw > MAX:
    - mode 0: x in {MAX, -MAX, MIN}
    - mode 1: x == MIN only
  - On overflow: ovf[i]=1. With SATURATE=1, lane = MAX; with SATURATE=0, lane = raw[WIDTH-1:0].
  - Otherwise ovf[i]=0 and lane = raw[WIDTH-1:0].
- Output hold behaviour:
  - denom lanes not yet rewritten keep their previous values during CALC.
  - All outputs hold between operations.
  - ovf is cleared to all-zero on capture.
- CHANNELS=1: CALC lasts one cycle; startout is high 2 cycles after the start edge.

Test Plan:
- WIDTH=8, CHANNELS=4, SATURATE=1, mode=0, X lanes {5,-3,0,127}, start at edge 0:
  - response: denom {6,4,1,127}, ovf=4'b1000
  - startout high only in the cycle after edge 5; busy high from edge 1 until startout completes
- Same configuration, mode=1, X lanes {-128,-1,100,-127}:
  - response: denom {127,1,100,127}, ovf=4'b0001
- SATURATE=0, mode=0, X lanes {-128,127,-127,0}:
  - response: denom {0x81,0x80,0x80,1}, ovf=4'b0111
- start pulsed again at edges 2 and 5 of an operation, with X changed at edge 1:
  - response: both extra pulses are ignored; results reflect the original X; exactly one startout
- reset asserted at edge 3 mid-CALC:
  - next cycle: denom=0, ovf=0, busy=0, and no startout
  - a fresh start then completes normally
- Back-to-back operations with start held high continuously:
  - response: a new capture occurs every CHANNELS+2 cycles (every 6 cycles at CHANNELS=4)
  - ovf cleared at each capture
